// File: rtl/seg_disp_arbiter_if.sv
// Requester-side handshake bundle for the seven-segment display arbiter:
// one valid/ready pair plus a 32-bit value and 8-bit digit mask per requester.
interface seg_disp_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ*8-1:0]  req_mask;

    modport master (
        output req_valid,
        output req_data,
        output req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_mask,
        output req_ready
    );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner arbitration for the shared 8-digit seven-segment display,
// with a guaranteed minimum on-screen time per owner and leading-zero blanking.
module seg_disp_arbiter #(
    parameter int  NREQ        = 4,
    parameter int  HOLD_CYCLES = 1000,
    parameter int  CNT_W       = 16,
    localparam int OW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_disp_arbiter_if.slave   req,
    input  logic                lz_blank,
    output logic [31:0]         data_out,
    output logic [7:0]          select_out,
    output logic [OW-1:0]       owner,
    output logic                owner_valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OW-1:0]    PTR_RESET   = OW'(NREQ - 1);

    // Returns {found, index} of the first valid requester after ptr, wrapping.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [OW-1:0]   ptr);
        logic [OW:0]   res;
        logic [OW-1:0] idx;
        logic          hit;
        res = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(ptr) + k) % NREQ);
            hit = !res[OW] && valid[idx];
            res = hit ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    // Digit k stays lit when it is digit 0 or any nibble at or above it is nonzero.
    function automatic logic [7:0] lead_zero_mask(input logic [31:0] value);
        logic [7:0] lzm;
        logic       seen;
        seen = 1'b0;
        lzm  = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            seen   = seen | (value[4*k +: 4] != 4'h0);
            lzm[k] = seen;
        end
        lzm[0] = 1'b1;
        return lzm;
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    logic [31:0]       data_r;
    logic [7:0]        mask_r;
    logic [OW-1:0]     owner_r;
    logic              owner_valid_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [OW-1:0]     rr_ptr_r;

    logic [OW:0]       pick_s;
    logic              win_found_s;
    logic [OW-1:0]     win_idx_s;
    logic              arb_s;
    logic [NREQ-1:0]   ready_raw_s;
    logic [NREQ-1:0]   ready_s;
    logic              accept_s;
    logic              grant_s;
    logic [OW-1:0]     acc_idx_s;
    logic [31:0]       acc_data_s;
    logic [7:0]        acc_mask_s;

    assign pick_s      = rr_pick(req.req_valid, rr_ptr_r);
    assign win_found_s = pick_s[OW];
    assign win_idx_s   = pick_s[OW-1:0];

    // Arbitration is open in IDLE and once the hold time of the owner has run out.
    assign arb_s       = (state_r == ST_IDLE) || (cnt_r == '0);

    // Readies are forced low while reset is asserted so no handshake can be lost.
    assign ready_s     = rst_n ? ready_raw_s : '0;
    assign req.req_ready = ready_s;

    assign accept_s    = |(req.req_valid & ready_s);
    assign grant_s     = accept_s && arb_s;
    assign acc_idx_s   = arb_s ? win_idx_s : owner_r;
    assign acc_data_s  = req.req_data[int'(acc_idx_s)*32 +: 32];
    assign acc_mask_s  = req.req_mask[int'(acc_idx_s)*8 +: 8];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: the first accept moves to SHOW, which is left only by reset.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_SHOW;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHOW: state_nx_s = ST_SHOW;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Ready generation: RR winner while arbitrating, otherwise only the owner.
    always_comb begin
        ready_raw_s = '0;
        case (state_r)
            ST_IDLE: begin
                ready_raw_s[win_idx_s] = win_found_s;
            end
            ST_SHOW: begin
                if (cnt_r == '0) begin
                    ready_raw_s[win_idx_s] = win_found_s;
                end else begin
                    ready_raw_s[owner_r] = req.req_valid[owner_r];
                end
            end
            default: ready_raw_s = '0;
        endcase
    end

    // Display value, owner tracking and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r        <= 32'h0000_0000;
            mask_r        <= 8'h00;
            owner_r       <= '0;
            owner_valid_r <= 1'b0;
            cnt_r         <= '0;
            rr_ptr_r      <= PTR_RESET;
        end else begin
            if (accept_s) begin
                data_r <= acc_data_s;
                mask_r <= acc_mask_s;
            end
            if (grant_s) begin
                owner_r       <= win_idx_s;
                owner_valid_r <= 1'b1;
                rr_ptr_r      <= win_idx_s;
                cnt_r         <= HOLD_RELOAD;
            end else if (cnt_r != '0) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

    assign data_out    = data_r;
    assign select_out  = lz_blank ? (mask_r & lead_zero_mask(data_r)) : mask_r;
    assign owner       = owner_r;
    assign owner_valid = owner_valid_r;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter: reset, single grant, blanking, hold time,
// round-robin rotation and asynchronous reset during SHOW.
module tb_seg_disp_arbiter;

    logic        clk;
    logic        rst_n;
    logic        lz_blank;
    logic [31:0] data_out8;
    logic [7:0]  select_out8;
    logic [1:0]  owner8;
    logic        owner_valid8;
    logic [31:0] data_out4;
    logic [7:0]  select_out4;
    logic [1:0]  owner4;
    logic        owner_valid4;

    int n_checks = 0;
    int n_errors = 0;

    seg_disp_arbiter_if #(.NREQ(4)) if8 ();
    seg_disp_arbiter_if #(.NREQ(4)) if4 ();

    seg_disp_arbiter #(.NREQ(4), .HOLD_CYCLES(8), .CNT_W(16)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (if8),
        .lz_blank    (lz_blank),
        .data_out    (data_out8),
        .select_out  (select_out8),
        .owner       (owner8),
        .owner_valid (owner_valid8)
    );

    seg_disp_arbiter #(.NREQ(4), .HOLD_CYCLES(4), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (if4),
        .lz_blank    (lz_blank),
        .data_out    (data_out4),
        .select_out  (select_out4),
        .owner       (owner4),
        .owner_valid (owner_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req8(input int i, input logic [31:0] d, input logic [7:0] m);
        if8.req_data[32*i +: 32] = d;
        if8.req_mask[8*i +: 8]   = m;
    endtask

    task automatic set_req4(input int i, input logic [31:0] d, input logic [7:0] m);
        if4.req_data[32*i +: 32] = d;
        if4.req_mask[8*i +: 8]   = m;
    endtask

    initial begin
        logic [3:0] exp_ready;
        int         exp_owner;

        rst_n         = 1'b0;
        lz_blank      = 1'b0;
        if8.req_valid = 4'b0000;
        if8.req_data  = '0;
        if8.req_mask  = '0;
        if4.req_valid = 4'b0000;
        if4.req_data  = '0;
        if4.req_mask  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_data",   data_out8, 32'h0000_0000);
        check_value("rst_select", 32'(select_out8), 32'h0000_0000);
        check_value("rst_ovalid", 32'(owner_valid8), 32'h0);
        check_value("rst_owner",  32'(owner8), 32'h0);
        check_value("rst_ready",  32'(if8.req_ready), 32'h0);
        rst_n = 1'b1;
        step();
        check_value("idle_ready",  32'(if8.req_ready), 32'h0);
        check_value("idle_ovalid", 32'(owner_valid8), 32'h0);

        // Single grant to requester 1
        set_req8(1, 32'h0000_1234, 8'hFF);
        if8.req_valid = 4'b0010;
        #1;
        check_value("grant1_ready", 32'(if8.req_ready), 32'h2);
        step();
        if8.req_valid = 4'b0000;
        #1;
        check_value("grant1_data",   data_out8, 32'h0000_1234);
        check_value("grant1_select", 32'(select_out8), 32'h0000_00FF);
        check_value("grant1_owner",  32'(owner8), 32'h1);
        check_value("grant1_ovalid", 32'(owner_valid8), 32'h1);

        // Leading-zero blanking reacts within the cycle
        lz_blank = 1'b1;
        #1;
        check_value("lz_1234", 32'(select_out8), 32'h0000_000F);
        set_req8(1, 32'h0000_0000, 8'hFF);
        if8.req_valid = 4'b0010;
        #1;
        check_value("owner_wr_ready", 32'(if8.req_ready), 32'h2);
        step();
        if8.req_valid = 4'b0000;
        #1;
        check_value("lz_zero_select", 32'(select_out8), 32'h0000_0001);
        check_value("lz_zero_data",   data_out8, 32'h0000_0000);
        lz_blank = 1'b0;
        #1;
        check_value("nolz_select", 32'(select_out8), 32'h0000_00FF);
        repeat (10) step();

        // Hold time: requester 0 owns for 8 cycles while requester 2 waits
        set_req8(0, 32'h0000_1111, 8'h0F);
        set_req8(2, 32'h0000_2222, 8'hFF);
        if8.req_valid = 4'b0001;
        #1;
        check_value("hold_grant0_ready", 32'(if8.req_ready), 32'h1);
        step();
        check_value("hold_owner0", 32'(owner8), 32'h0);
        check_value("hold_data0",  data_out8, 32'h0000_1111);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                set_req8(0, 32'h0000_ABCD, 8'h0F);
                if8.req_valid = 4'b0101;
                exp_ready = 4'b0001;
            end else begin
                if8.req_valid = 4'b0100;
                exp_ready = (k == 7) ? 4'b0100 : 4'b0000;
            end
            #1;
            check_value($sformatf("hold_ready_k%0d", k), 32'(if8.req_ready), 32'(exp_ready));
            check_value($sformatf("hold_owner_k%0d", k), 32'(owner8), 32'h0);
            step();
            if (k == 2) begin
                check_value("hold_owner_update", data_out8, 32'h0000_ABCD);
            end
        end
        check_value("hold_switch_owner", 32'(owner8), 32'h2);
        check_value("hold_switch_data",  data_out8, 32'h0000_2222);
        check_value("hold_switch_sel",   32'(select_out8), 32'h0000_00FF);
        if8.req_valid = 4'b0000;

        // Asynchronous reset while SHOW has cnt == 3
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_value("arst_data",   data_out8, 32'h0000_0000);
        check_value("arst_select", 32'(select_out8), 32'h0000_0000);
        check_value("arst_ovalid", 32'(owner_valid8), 32'h0);
        check_value("arst_owner",  32'(owner8), 32'h0);
        set_req8(0, 32'h0000_0050, 8'h3C);
        set_req8(3, 32'h0000_0777, 8'hFF);
        if8.req_valid = 4'b1001;
        #1;
        check_value("arst_ready_held", 32'(if8.req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_value("post_rst_ready", 32'(if8.req_ready), 32'h1);
        step();
        check_value("post_rst_owner",  32'(owner8), 32'h0);
        check_value("post_rst_data",   data_out8, 32'h0000_0050);
        check_value("post_rst_select", 32'(select_out8), 32'h0000_003C);
        check_value("post_rst_ovalid", 32'(owner_valid8), 32'h1);
        if8.req_valid = 4'b0000;

        // Round-robin rotation with all requesters valid, hold of 4
        for (int i = 0; i < 4; i++) begin
            set_req4(i, 32'h0000_00A0 + 32'(i), 8'hFF);
        end
        if4.req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            exp_owner = (c / 4) % 4;
            #1;
            check_value($sformatf("rr_ready_c%0d", c), 32'(if4.req_ready), 32'(4'b0001 << exp_owner));
            check_value($sformatf("rr_onehot_c%0d", c), 32'($countones(if4.req_ready) <= 1), 32'h1);
            step();
            check_value($sformatf("rr_owner_c%0d", c), 32'(owner4), 32'(exp_owner));
            check_value($sformatf("rr_data_c%0d", c), data_out4, 32'h0000_00A0 + 32'(exp_owner));
        end
        if4.req_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the 8-digit seven-segment display between NREQ requesters, such as the CPU MMIO write port, the PC/debug monitor and the keyboard echo.
- Each requester offers a 32-bit hex value and an 8-bit digit-enable mask over a valid/ready handshake.
- The block grants the display round-robin and guarantees each granted owner a minimum on-screen time of HOLD_CYCLES.
- Its registered value/mask outputs drive the display decoder's data_in/select inputs directly, with optional leading-zero blanking.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 1000, minimum cycles an accepted owner keeps the display before another requester may take it (>=1).
- CNT_W, 16, hold counter width; must satisfy HOLD_CYCLES <= 2^CNT_W.
- OW, derived, clog2(NREQ), owner index width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- req_valid  in  NREQ  requester i offers a value.
- req_ready  out  NREQ  handshake accept; a transfer occurs on an edge where valid[i]&ready[i].
- req_data  in  NREQ*32  value of requester i at bits [32i+31:32i].
- req_mask  in  NREQ*8  digit enables of requester i at bits [8i+7:8i].
- lz_blank  in  1  1 = blank leading zero digits.
- data_out  out  32  value to the display decoder's data_in.
- select_out  out  8  digit enables to the display decoder's select.
- owner  out  OW  index of the current owner.
- owner_valid  out  1  1 once any requester has been accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; data_q=0, mask_q=0, owner=0, owner_valid=0, cnt=0, rr_ptr=NREQ-1.
  - All req_ready=0, so select_out=0 and data_out=0.
- States: IDLE, SHOW.
- Round-robin pick:
  - Search indices rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - The first index with valid set wins.
  - rr_ptr always equals the last accepted index.
- IDLE:
  - The RR winner gets ready=1 combinationally in the same cycle; all other readies are 0.
  - On the accept edge: data_q/mask_q <= the winner's data/mask, owner <= winner, owner_valid <= 1, rr_ptr <= winner, cnt <= HOLD_CYCLES-1, state <= SHOW.
- SHOW with cnt>0:
  - Only the current owner sees ready=(1 when it is valid).
  - An owner transfer updates data_q/mask_q on the next edge; cnt and rr_ptr are unchanged.
  - cnt decrements by 1 every edge regardless of traffic.
  - Other requesters are stalled with ready=0 and may hold valid indefinitely.
- SHOW with cnt==0:
  - Full RR arbitration; the owner is searched last because rr_ptr=owner.
  - The winner's transfer behaves as in IDLE: latch, owner<=winner, cnt reload. This applies even when the winner is the same owner.
  - With no valid requester, the display holds its last value indefinitely; cnt stays 0 (no underflow).
- Outputs: data_out=data_q at 1-cycle latency from the accept edge. owner and owner_valid are registered.
- Leading-zero blanking:
  - When lz_blank=0, select_out=mask_q.
  - When lz_blank=1, select_out=mask_q & lzm. lzm bit k=1 iff k=0 or some nibble j>=k of data_q is nonzero.
  - The result is combinational from registers and lz_blank, so it reacts within the same cycle.
  - Example: data_q=0 gives lzm=8'h01.
- Handshake rules:
  - At most one req_ready is high per cycle.
  - Ready never depends on the requester's own data.
  - A requester may drop valid before acceptance without side effects.
- There is no state beyond IDLE/SHOW; SHOW is left only by reset.
- Reset mid-SHOW: all state is cleared immediately (async). The display blanks in the same cycle and the first post-reset grant goes to the lowest valid index starting from 0.

Test Plan:
- Reset check: hold rst_n=0, then release -> data_out=0, select_out=0, owner_valid=0, req_ready=0 while no valid.
- Single grant: req_valid=4'b0010, data1=32'h0000_1234, mask1=8'hFF, lz_blank=0 -> ready[1]=1 in the same cycle. The next cycle shows data_out=32'h0000_1234, select_out=8'hFF, owner=1, owner_valid=1.
- Blanking: repeat with lz_blank=1 -> select_out=8'h0F; then owner writes 0 -> select_out=8'h01.
- Hold: HOLD_CYCLES=8, req0 accepted at edge E0, req2 valid from E1 -> ready[2]=0 through E7, ready[2]=1 after E7, owner=2 after E8. req0 updates data 32'hABCD at E3 -> data_out=32'hABCD after E3 with the switch timing unchanged.
- Round-robin: HOLD_CYCLES=4, all four valid continuously -> owner sequence 0,1,2,3,0, each held exactly 4 cycles, never two readies high at once.
- Async reset mid-SHOW: assert rst_n=0 at cnt=3 between edges -> outputs 0 immediately. After release with req_valid=4'b1001 -> owner=0 is granted first.
